// File: rtl/dc_dma_sequencer.sv
// G1 DMA read sequencer: MCU-filled FWFT word FIFO drained onto the DC bus via DMARQ/DMACK/RD.
// Latency: DC_RD pin edge to FIFO pop is SYNC_STAGES+1 cycles; DC_DMARQ is registered.
// Backpressure: DMARQ drops while the FIFO is empty; pushes into a full FIFO are dropped and flagged in fifo_ovf.
// Optional burst limiting is enabled with `define DMA_BURST_LIMIT_EN.
module dc_dma_sequencer #(
    parameter int FIFO_AW     = 5,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int BURST_LEN   = 8
) (
    input  logic                CLK_48_MHz,
    input  logic                MCU_RSTn,
    input  logic                cfg_start,
    input  logic                cfg_abort,
    input  logic [CNT_W-1:0]    cfg_word_count,
    input  logic                fifo_wr_en,
    input  logic [15:0]         fifo_wr_data,
    output logic                fifo_full,
    output logic [FIFO_AW:0]    fifo_level,
    output logic                fifo_ovf,
    input  logic                DC_DMACK,
    input  logic                DC_RD,
    output logic                DC_DMARQ,
    output logic [15:0]         DC_DATA_OUT,
    output logic                DC_DATA_OUT_EN,
    output logic                busy,
    output logic [CNT_W-1:0]    remaining,
    output logic                done_irq,
    input  logic                irq_clr
);

    localparam int              DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_DATA, S_REQ, S_XFER, S_DONE, S_GAP
    } state_t;

    state_t                 r_state, w_next;
    logic [SYNC_STAGES-1:0] r_ack_sync, r_rd_sync;
    logic                   r_rd_d;
    logic [15:0]            r_mem [DEPTH];
    logic [FIFO_AW:0]       r_wp, r_rp;
    logic                   r_dmarq, r_ovf, r_done;
    logic [CNT_W-1:0]       r_remaining;
    logic                   w_ack_s, w_rd_s, w_rd_rise, w_rd_fall;
    logic [FIFO_AW:0]       w_level;
    logic                   w_empty, w_full, w_push, w_pop, w_empty_after;
`ifdef DMA_BURST_LIMIT_EN
    logic [$clog2(BURST_LEN+1)-1:0] r_burst_cnt;
    logic [1:0]                     r_gap_cnt;
`endif

    assign w_ack_s   = r_ack_sync[SYNC_STAGES-1];
    assign w_rd_s    = r_rd_sync[SYNC_STAGES-1];
    assign w_rd_rise = w_rd_s & ~r_rd_d;
    assign w_rd_fall = ~w_rd_s & r_rd_d;

    assign w_level       = r_wp - r_rp;
    assign w_empty       = (w_level == '0);
    assign w_full        = (w_level == DEPTH_L);
    assign w_push        = fifo_wr_en & ~w_full;
    // A pop of the last held word leaves the FIFO empty unless a push lands in the same cycle.
    assign w_empty_after = (w_level == (FIFO_AW+1)'(1)) & ~w_push;

    // Bring the asynchronous DC strobes into the 48 MHz domain and keep the previous RD for edge detection.
    always_ff @(posedge CLK_48_MHz or negedge MCU_RSTn) begin
        if (!MCU_RSTn) begin
            r_ack_sync <= '0;
            r_rd_sync  <= '0;
            r_rd_d     <= 1'b0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], DC_DMACK};
            r_rd_sync  <= {r_rd_sync[SYNC_STAGES-2:0], DC_RD};
            r_rd_d     <= w_rd_s;
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge CLK_48_MHz) begin
        if (w_push && !cfg_abort) r_mem[r_wp[FIFO_AW-1:0]] <= fifo_wr_data;
    end

    // FIFO pointers and sticky overflow; abort flushes, overflow set beats irq_clr.
    always_ff @(posedge CLK_48_MHz or negedge MCU_RSTn) begin
        if (!MCU_RSTn) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (cfg_abort) begin
                r_wp <= '0;
                r_rp <= '0;
            end else begin
                r_wp <= r_wp + (FIFO_AW+1)'(w_push);
                r_rp <= r_rp + (FIFO_AW+1)'(w_pop);
            end
            if (fifo_wr_en && w_full) r_ovf <= 1'b1;
            else if (irq_clr)         r_ovf <= 1'b0;
        end
    end

    // Next-state and pop decision; abort overrides everything else.
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg_start) w_next = (cfg_word_count == '0) ? S_DONE : S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (!w_empty) w_next = S_REQ;
            end
            S_REQ: begin
                if (w_ack_s && w_rd_rise) w_next = S_XFER;
            end
            S_XFER: begin
                if (w_rd_fall && !w_empty) begin
                    w_pop = 1'b1;
                    if (r_remaining <= CNT_W'(1)) w_next = S_DONE;
`ifdef DMA_BURST_LIMIT_EN
                    else if (r_burst_cnt == ($clog2(BURST_LEN+1))'(BURST_LEN-1)) w_next = S_GAP;
`endif
                    else if (w_empty_after) w_next = S_WAIT_DATA;
                    else                    w_next = S_REQ;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
`ifdef DMA_BURST_LIMIT_EN
            // Three GAP cycles plus the WAIT_DATA hand-off keep DMARQ low for four cycles.
            S_GAP: begin
                if (r_gap_cnt == 2'd2) w_next = S_WAIT_DATA;
            end
`endif
            default: w_next = S_IDLE;
        endcase
        if (cfg_abort) begin
            w_next = S_IDLE;
            w_pop  = 1'b0;
        end
    end

    // State, registered DMARQ, word counter and sticky completion flag.
    always_ff @(posedge CLK_48_MHz or negedge MCU_RSTn) begin
        if (!MCU_RSTn) begin
            r_state     <= S_IDLE;
            r_dmarq     <= 1'b0;
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_dmarq <= (w_next == S_REQ) || (w_next == S_XFER);
            if (cfg_abort)                           r_remaining <= '0;
            else if (r_state == S_IDLE && cfg_start) r_remaining <= cfg_word_count;
            else if (w_pop && r_remaining != '0)     r_remaining <= r_remaining - CNT_W'(1);
            if (r_state == S_DONE && !cfg_abort) r_done <= 1'b1;
            else if (irq_clr)                    r_done <= 1'b0;
        end
    end

`ifdef DMA_BURST_LIMIT_EN
    // Words popped in the current burst, and cycles spent in GAP.
    always_ff @(posedge CLK_48_MHz or negedge MCU_RSTn) begin
        if (!MCU_RSTn) begin
            r_burst_cnt <= '0;
            r_gap_cnt   <= '0;
        end else begin
            if (cfg_abort || (r_state == S_IDLE && cfg_start) || r_state == S_GAP) r_burst_cnt <= '0;
            else if (w_pop) r_burst_cnt <= r_burst_cnt + 1'b1;
            r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 2'd1 : 2'd0;
        end
    end
`endif

    assign fifo_full      = w_full;
    assign fifo_level     = w_level;
    assign fifo_ovf       = r_ovf;
    assign DC_DMARQ       = r_dmarq;
    assign DC_DATA_OUT    = w_empty ? 16'h0000 : r_mem[r_rp[FIFO_AW-1:0]];
    assign DC_DATA_OUT_EN = (r_state == S_XFER) & w_ack_s & w_rd_s;
    assign busy           = (r_state != S_IDLE);
    assign remaining      = r_remaining;
    assign done_irq       = r_done;

endmodule

// File: tb/tb_dc_dma_sequencer.sv
// Randomized bench for dc_dma_sequencer against a queue-based transfer model.
// Latency: all checks sampled on the falling clock edge.
// Backpressure: the emulated DC host only strobes RD after seeing DMARQ, with bounded waits.
module tb_dc_dma_sequencer;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0, cfg_abort = 1'b0, irq_clr = 1'b0;
    logic [15:0] cfg_word_count = '0;
    logic        fifo_wr_en = 1'b0;
    logic [15:0] fifo_wr_data = '0;
    logic        fifo_full, fifo_ovf, dmarq, data_en, busy, done_irq;
    logic [5:0]  fifo_level;
    logic        dmack = 1'b0, rd = 1'b0;
    logic [15:0] data_out, remaining;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] model_q[$];

    dc_dma_sequencer #(.FIFO_AW(5), .CNT_W(16), .SYNC_STAGES(SYNC), .BURST_LEN(8)) dut (
        .CLK_48_MHz(clk), .MCU_RSTn(rst_n),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_word_count(cfg_word_count),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_full(fifo_full), .fifo_level(fifo_level), .fifo_ovf(fifo_ovf),
        .DC_DMACK(dmack), .DC_RD(rd), .DC_DMARQ(dmarq),
        .DC_DATA_OUT(data_out), .DC_DATA_OUT_EN(data_en),
        .busy(busy), .remaining(remaining), .done_irq(done_irq), .irq_clr(irq_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        fifo_wr_en   = 1'b1;
        fifo_wr_data = w;
        @(negedge clk);
        fifo_wr_en   = 1'b0;
    endtask

    task automatic push_model(input logic [15:0] w);
        push(w);
        model_q.push_back(w);
    endtask

    task automatic start(input logic [15:0] c);
        cfg_word_count = c;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic pulse_clr();
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
    endtask

    task automatic wait_dmarq(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (dmarq) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk("dmarq_wait", dmarq, 1);
    endtask

    // Host-side read of one word: wait for DMARQ, strobe DMACK/RD, compare bus data.
    task automatic read_word(input string tag);
        bit ok;
        logic [15:0] exp;
        wait_dmarq(ok);
        if (!ok) return;
        exp = model_q.pop_front();
        dmack = 1'b1;
        rd    = 1'b1;
        repeat (SYNC + 3 + $urandom_range(0, 3)) @(negedge clk);
        chk({tag, "_en"}, data_en, 1);
        chk({tag, "_data"}, data_out, exp);
        rd = 1'b0;
        repeat (2) @(negedge clk);
        dmack = 1'b0;
        repeat (2) @(negedge clk);
    endtask

`ifdef DMA_BURST_LIMIT_EN
    int runs[$];
    int run_len = 0;
    bit mon_en = 1'b0;
    // Record each stretch of DMARQ-low cycles while a transfer is busy.
    always @(negedge clk) begin
        if (!mon_en) begin
            run_len = 0;
        end else if (busy) begin
            if (!dmarq) run_len++;
            else if (run_len > 0) begin runs.push_back(run_len); run_len = 0; end
        end
    end
`endif

    initial begin
        bit ok;
        int cnt, pushed, n;
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        int cnt, pushed, n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dmarq", dmarq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_done", done_irq, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_data", data_out, 0);

        // Asynchronous reset while requesting
        push(16'hABCD);
        start(16'd1);
        wait_dmarq(ok);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dmarq", dmarq, 0);
        chk("arst_busy", busy, 0);
        chk("arst_level", fifo_level, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Four directed words
        for (int i = 1; i <= 4; i++) push_model(16'(i * 16'h1111));
        chk("four_level", fifo_level, 4);
        start(16'd4);
        for (int i = 0; i < 4; i++) read_word("four");
        chk("four_dmarq_drop", dmarq, 0);
        chk("four_done", done_irq, 1);
        chk("four_rem", remaining, 0);
        chk("four_busy", busy, 0);
        pulse_clr();
        chk("four_clr", done_irq, 0);

        // Starved FIFO pauses the request
        push_model(16'h5A01);
        start(16'd3);
        read_word("starve");
        repeat (3) @(negedge clk);
        chk("starve_dmarq", dmarq, 0);
        chk("starve_busy", busy, 1);
        chk("starve_rem", remaining, 2);
        push_model(16'h5A02);
        push_model(16'h5A03);
        read_word("starve");
        read_word("starve");
        chk("starve_done", done_irq, 1);
        pulse_clr();

        // Zero-length transfer
        cfg_word_count = 16'd0;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("zero_dmarq1", dmarq, 0);
        @(negedge clk);
        chk("zero_dmarq2", dmarq, 0);
        chk("zero_done", done_irq, 1);
        pulse_clr();

        // Strobes toggling while idle never enable the bus
        dmack = 1'b1; rd = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_en", data_en, 0);
        dmack = 1'b0; rd = 1'b0;
        repeat (3) @(negedge clk);

        // Overflow at depth 32
        for (int i = 0; i < 33; i++) push(16'(i));
        chk("ovf_full", fifo_full, 1);
        chk("ovf_flag", fifo_ovf, 1);
        chk("ovf_level", fifo_level, 32);
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        chk("flush_level", fifo_level, 0);
        pulse_clr();
        chk("ovf_clr", fifo_ovf, 0);

        // Abort mid-transfer
        for (int i = 0; i < 10; i++) push(16'(16'h7000 + i));
        start(16'd10);
        wait_dmarq(ok);
        dmack = 1'b1; rd = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (data_en) begin ok = 1'b1; break; end
        end
        chk("abort_reach_xfer", ok, 1);
        chk("abort_rem_before", remaining, 10);
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        chk("abort_dmarq", dmarq, 0);
        chk("abort_en", data_en, 0);
        chk("abort_level", fifo_level, 0);
        chk("abort_rem", remaining, 0);
        rd = 1'b0;
        repeat (5) @(negedge clk);
        dmack = 1'b0;
        chk("abort_no_done", done_irq, 0);
        chk("abort_busy", busy, 0);

        // Randomized transfers with interleaved refills
        for (int t = 0; t < 12; t++) begin
            cnt = $urandom_range(1, 12);
            pushed = $urandom_range(1, cnt);
            for (int i = 0; i < pushed; i++) push_model(16'($urandom));
            start(16'(cnt));
            for (int w = 0; w < cnt; w++) begin
                if (model_q.size() == 0) begin
                    chk("rnd_starve_dmarq", dmarq, 0);
                    n = $urandom_range(1, cnt - pushed);
                    for (int i = 0; i < n; i++) push_model(16'($urandom));
                    pushed += n;
                end
                read_word("rnd");
                chk("rnd_rem", remaining, 32'(cnt - w - 1));
                chk("rnd_level", fifo_level, 32'(model_q.size()));
            end
            chk("rnd_done", done_irq, 1);
            chk("rnd_idle", busy, 0);
            pulse_clr();
        end

`ifdef DMA_BURST_LIMIT_EN
        // Burst limit: DMARQ low exactly four cycles after words 8 and 16
        for (int i = 0; i < 20; i++) push_model(16'(16'h9000 + i));
        mon_en = 1'b1;
        start(16'd20);
        for (int i = 0; i < 20; i++) read_word("burst");
        mon_en = 1'b0;
        chk("burst_done", done_irq, 1);
        chk("burst_runs", runs.size(), 3);
        if (runs.size() == 3) begin
            chk("burst_gap1", runs[1], 4);
            chk("burst_gap2", runs[2], 4);
        end
        pulse_clr();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
